d2d_credit_scheduler: RTL and testbench

Shares one die-to-die link transmit slot among NUM_REQ requesters (virtual channels). It keeps a per-channel credit counter, arbitrates round-robin among requesters that have credit, and issues at most one grant per cycle. It also runs a small link bring-up state machine that reloads all credit pools whenever the link comes up. The block sits between the on-die producers and the die-to-die link transmitter in the multi-chip module fabric.

---
 rtl/d2d_credit_scheduler.sv | 139 +++++++++++++
 tb/tb_d2d_credit_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d2d_credit_scheduler.sv
// Credit-based round-robin scheduler for one die-to-die transmit slot,
// with a link bring-up FSM that reloads all credit pools on link-up.
module d2d_credit_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int CREDITS   = 8,
  parameter int INIT_WAIT = 16,
  localparam int VW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(CREDITS) + 1,
  localparam int IW = $clog2(INIT_WAIT + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               link_up,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               link_valid,
  output logic [VW-1:0]      link_vc,
  input  logic               cred_ret_valid,
  input  logic [VW-1:0]      cred_ret_vc,
  output logic [NUM_REQ-1:0] credit_avail,
  output logic [1:0]         state,
  output logic               credit_err
);

  typedef enum logic [1:0] {
    DOWN   = 2'd0,
    INIT   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  localparam logic [CW-1:0] CMAX  = CW'(CREDITS);
  localparam logic [IW-1:0] ILAST = IW'(INIT_WAIT - 1);

  state_t         state_q, state_d;
  logic [IW-1:0]  init_q, init_d;
  logic [CW-1:0]  cnt_q [NUM_REQ];
  logic [CW-1:0]  cnt_d [NUM_REQ];
  logic [VW-1:0]  ptr_q;
  logic [VW-1:0]  win;
  logic           found;
  logic           active_ok;
  logic           do_gnt;
  logic           ret_ok;
  logic           bad_vc;
  logic           err_set;
  logic [NUM_REQ-1:0] elig;

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    unique case (state_q)
      DOWN: begin
        init_d = '0;
        if (link_up) state_d = INIT;
      end
      INIT: begin
        if (!link_up) state_d = DOWN;
        else if (init_q == ILAST) state_d = ACTIVE;
        else init_d = init_q + 1'b1;
      end
      ACTIVE: begin
        if (!link_up) state_d = DOWN;
      end
      default: state_d = DOWN;
    endcase
  end

  // A link drop in ACTIVE suppresses grants and returns on that same edge.
  assign active_ok = (state_q == ACTIVE) && link_up;
  assign ret_ok    = active_ok && cred_ret_valid;
  assign bad_vc    = int'(cred_ret_vc) >= NUM_REQ;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = req[i] && (cnt_q[i] != '0);
  end

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!found && elig[(int'(ptr_q) + off) % NUM_REQ]) begin
        found = 1'b1;
        win   = VW'((int'(ptr_q) + off) % NUM_REQ);
      end
    end
  end

  assign do_gnt = active_ok && found;

  always_comb begin
    err_set = ret_ok && bad_vc;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!active_ok) begin
        cnt_d[i] = CMAX;
      end else begin
        if (ret_ok && !bad_vc && int'(cred_ret_vc) == i) begin
          if (!(do_gnt && int'(win) == i)) begin
            if (cnt_q[i] == CMAX) err_set = 1'b1;
            else cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else if (do_gnt && int'(win) == i) begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= DOWN;
      init_q     <= '0;
      ptr_q      <= '0;
      gnt        <= '0;
      link_valid <= 1'b0;
      link_vc    <= '0;
      credit_err <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= CMAX;
    end else begin
      state_q    <= state_d;
      init_q     <= init_d;
      link_valid <= do_gnt;
      gnt        <= do_gnt ? (NUM_REQ'(1) << win) : '0;
      link_vc    <= do_gnt ? win : '0;
      if (do_gnt) ptr_q <= VW'((int'(win) + 1) % NUM_REQ);
      if (err_set) credit_err <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      credit_avail[i] = (cnt_q[i] != '0);
  end

  assign state = state_q;

endmodule

// File: tb/tb_d2d_credit_scheduler.sv
// Directed bench for d2d_credit_scheduler (NUM_REQ=4, CREDITS=8,
// INIT_WAIT=16); inputs change and outputs are sampled on negedge.
module tb_d2d_credit_scheduler;

  logic       clk = 1'b0;
  logic       rstn;
  logic       link_up;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       link_valid;
  logic [1:0] link_vc;
  logic       cred_ret_valid;
  logic [1:0] cred_ret_vc;
  logic [3:0] credit_avail;
  logic [1:0] state;
  logic       credit_err;

  int total = 0;
  int bad = 0;

  d2d_credit_scheduler #(
    .NUM_REQ(4), .CREDITS(8), .INIT_WAIT(16)
  ) dut (
    .clk(clk), .rstn(rstn), .link_up(link_up), .req(req),
    .gnt(gnt), .link_valid(link_valid), .link_vc(link_vc),
    .cred_ret_valid(cred_ret_valid), .cred_ret_vc(cred_ret_vc),
    .credit_avail(credit_avail), .state(state),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rstn = 1'b0; link_up = 1'b0; req = '0;
    cred_ret_valid = 1'b0; cred_ret_vc = '0;
    repeat (3) @(negedge clk);
    total++;
    if (gnt !== 4'b0 || link_valid !== 1'b0 || link_vc !== 2'd0) begin
      bad++;
      $display("FAIL reset_gnt: gnt=%b valid=%b vc=%0d want 0/0/0",
               gnt, link_valid, link_vc);
    end
    total++;
    if (credit_avail !== 4'hf || state !== 2'd0 || credit_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: avail=%b state=%0d err=%b want 1111/0/0",
               credit_avail, state, credit_err);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bringup();
    link_up = 1'b1; req = 4'b0001;
    @(negedge clk);
    total++;
    if (state !== 2'd1) begin
      bad++; $display("FAIL bringup_init: state=%0d want 1", state);
    end
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      total++;
      if (state !== 2'd1 || gnt !== 4'b0) begin
        bad++;
        $display("FAIL bringup_wait%0d: state=%0d gnt=%b want 1/0000",
                 k, state, gnt);
      end
    end
    @(negedge clk);
    total++;
    if (state !== 2'd2 || gnt !== 4'b0) begin
      bad++;
      $display("FAIL bringup_active: state=%0d gnt=%b want 2/0000",
               state, gnt);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++;
      if (c < 8) begin
        if (gnt !== 4'b0001 || link_valid !== 1'b1 || link_vc !== 2'd0) begin
          bad++;
          $display("FAIL bringup_gnt%0d: gnt=%b valid=%b vc=%0d want 0001/1/0",
                   c, gnt, link_valid, link_vc);
        end
      end else if (gnt !== 4'b0 || link_valid !== 1'b0) begin
        bad++;
        $display("FAIL bringup_stop%0d: gnt=%b valid=%b want 0000/0",
                 c, gnt, link_valid);
      end
    end
    total++;
    if (credit_avail !== 4'b1110) begin
      bad++;
      $display("FAIL bringup_avail: avail=%b want 1110", credit_avail);
    end
  endtask

  task automatic test_credit_return();
    cred_ret_valid = 1'b1; cred_ret_vc = 2'd0;
    @(negedge clk);
    cred_ret_valid = 1'b0;
    total++;
    if (credit_avail !== 4'hf || gnt !== 4'b0) begin
      bad++;
      $display("FAIL ret_update: avail=%b gnt=%b want 1111/0000",
               credit_avail, gnt);
    end
    @(negedge clk);
    total++;
    if (gnt !== 4'b0001) begin
      bad++; $display("FAIL ret_grant: gnt=%b want 0001", gnt);
    end
    @(negedge clk);
    total++;
    if (gnt !== 4'b0 || credit_avail !== 4'b1110) begin
      bad++;
      $display("FAIL ret_drain: gnt=%b avail=%b want 0000/1110",
               gnt, credit_avail);
    end
    req = '0;
    cred_ret_valid = 1'b1; cred_ret_vc = 2'd0;
    repeat (8) @(negedge clk);
    cred_ret_valid = 1'b0;
    @(negedge clk);
    total++;
    if (credit_avail !== 4'hf || credit_err !== 1'b0) begin
      bad++;
      $display("FAIL ret_refill: avail=%b err=%b want 1111/0",
               credit_avail, credit_err);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_vc;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_vc = 2'((1 + i) % 4);
      total++;
      if (gnt !== (4'b0001 << exp_vc) || link_vc !== exp_vc ||
          link_valid !== 1'b1) begin
        bad++;
        $display("FAIL rr_%0d: gnt=%b vc=%0d want vc=%0d",
                 i, gnt, link_vc, exp_vc);
      end
      cred_ret_valid = 1'b1; cred_ret_vc = exp_vc;
      if (i == 7) req = '0;
    end
    @(negedge clk);
    cred_ret_valid = 1'b0;
    total++;
    if (gnt !== 4'b0 || credit_avail !== 4'hf || credit_err !== 1'b0) begin
      bad++;
      $display("FAIL rr_end: gnt=%b avail=%b err=%b want 0000/1111/0",
               gnt, credit_avail, credit_err);
    end
  endtask

  task automatic test_same_edge();
    req = 4'b0100;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (gnt !== 4'b0100) begin
        bad++; $display("FAIL se_drain%0d: gnt=%b want 0100", i, gnt);
      end
    end
    req = 4'b0100;
    cred_ret_valid = 1'b1; cred_ret_vc = 2'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (gnt !== 4'b0100 || credit_avail[2] !== 1'b1) begin
        bad++;
        $display("FAIL se_hold%0d: gnt=%b avail=%b want 0100/x1xx",
                 i, gnt, credit_avail);
      end
    end
    req = '0; cred_ret_valid = 1'b0;
    @(negedge clk);
    total++;
    if (credit_avail !== 4'hf || credit_err !== 1'b0) begin
      bad++;
      $display("FAIL se_after: avail=%b err=%b want 1111/0",
               credit_avail, credit_err);
    end
    cred_ret_valid = 1'b1; cred_ret_vc = 2'd2;
    repeat (7) @(negedge clk);
    cred_ret_valid = 1'b0;
    @(negedge clk);
    total++;
    if (credit_err !== 1'b0) begin
      bad++;
      $display("FAIL se_refill: err=%b want 0 (counter was 1)", credit_err);
    end
  endtask

  task automatic test_overflow();
    cred_ret_valid = 1'b1; cred_ret_vc = 2'd1;
    @(negedge clk);
    cred_ret_valid = 1'b0;
    total++;
    if (credit_err !== 1'b1 || credit_avail !== 4'hf) begin
      bad++;
      $display("FAIL ovf_set: err=%b avail=%b want 1/1111",
               credit_err, credit_avail);
    end
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    total++;
    if (gnt !== 4'b0010) begin
      bad++; $display("FAIL ovf_gnt: gnt=%b want 0010", gnt);
    end
    cred_ret_valid = 1'b1; cred_ret_vc = 2'd1;
    @(negedge clk);
    cred_ret_valid = 1'b0;
    @(negedge clk);
    total++;
    if (credit_err !== 1'b1 || gnt !== 4'b0) begin
      bad++;
      $display("FAIL ovf_sticky: err=%b gnt=%b want 1/0000", credit_err, gnt);
    end
  endtask

  task automatic test_async_reset();
    req = 4'b0001;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0001) begin
      bad++; $display("FAIL ar_pre: gnt=%b want 0001", gnt);
    end
    #1 rstn = 1'b0;
    #1;
    total++;
    if (gnt !== 4'b0 || link_valid !== 1'b0 || state !== 2'd0) begin
      bad++;
      $display("FAIL ar_clear: gnt=%b valid=%b state=%0d want 0000/0/0",
               gnt, link_valid, state);
    end
    total++;
    if (credit_err !== 1'b0 || credit_avail !== 4'hf) begin
      bad++;
      $display("FAIL ar_regs: err=%b avail=%b want 0/1111",
               credit_err, credit_avail);
    end
    req = '0; link_up = 1'b0;
    #1 rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_link_drop();
    int n;
    link_up = 1'b1;
    n = 0;
    while (state !== 2'd2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (state !== 2'd2) begin
      bad++; $display("FAIL ld_bringup: state=%0d want 2 within 40", state);
    end
    req = 4'b1111;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0001) begin
      bad++; $display("FAIL ld_first: gnt=%b want 0001", gnt);
    end
    @(negedge clk);
    total++;
    if (gnt !== 4'b0010) begin
      bad++; $display("FAIL ld_second: gnt=%b want 0010", gnt);
    end
    link_up = 1'b0;
    @(negedge clk);
    total++;
    if (gnt !== 4'b0 || link_valid !== 1'b0 || state !== 2'd0 ||
        credit_avail !== 4'hf) begin
      bad++;
      $display("FAIL ld_drop: gnt=%b valid=%b state=%0d avail=%b want 0000/0/0/1111",
               gnt, link_valid, state, credit_avail);
    end
    cred_ret_valid = 1'b1; cred_ret_vc = 2'd1;
    repeat (3) @(negedge clk);
    cred_ret_valid = 1'b0;
    req = '0;
    @(negedge clk);
    total++;
    if (credit_err !== 1'b0 || state !== 2'd0 || gnt !== 4'b0) begin
      bad++;
      $display("FAIL ld_down_ret: err=%b state=%0d gnt=%b want 0/0/0000",
               credit_err, state, gnt);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_credit_return();
    test_round_robin();
    test_same_edge();
    test_overflow();
    test_async_reset();
    test_link_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
